// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master basil bus arbiter: FSM encoding,
// command latch width and read-latency limits.
package bus_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_ACK    = 2'd3;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;

  // Latched command layout is {wr, add, wdata}.
  function automatic int cmd_width(input int abw);
    return 1 + abw + 8;
  endfunction

  // Out-of-range latencies are pinned to the nearest legal value so the
  // 3-bit wait counter can never be loaded with zero.
  function automatic logic [2:0] lat_clamp(input int lat);
    if (lat < RD_LAT_MIN) return 3'(RD_LAT_MIN);
    if (lat > RD_LAT_MAX) return 3'(RD_LAT_MAX);
    return 3'(lat);
  endfunction

endpackage

// File: rtl/bus_arb_req_slot.sv
// One request slot per master: latches a posted command, holds BUSY until
// the arbiter reports completion, and flags requests that arrive while busy.
module bus_arb_req_slot
  import bus_arb_pkg::*;
#(
  parameter int ABUSWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic                 i_wr,
  input  logic [ABUSWIDTH-1:0] i_add,
  input  logic [7:0]           i_wdata,
  input  logic                 i_done,
  output logic                 o_busy,
  output logic                 o_err,
  output logic                 o_wr,
  output logic [ABUSWIDTH-1:0] o_add,
  output logic [7:0]           o_wdata
);

  localparam int CW = cmd_width(ABUSWIDTH);

  logic          r_busy;
  logic          r_err;
  logic [CW-1:0] r_cmd;

  // A request in the completion cycle still sees BUSY high, so it is
  // rejected with ERR rather than silently queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_err  <= 1'b0;
      r_cmd  <= '0;
    end else begin
      r_err <= i_req & r_busy;
      if (i_done) begin
        r_busy <= 1'b0;
      end else if (i_req && !r_busy) begin
        r_busy <= 1'b1;
        r_cmd  <= {i_wr, i_add, i_wdata};
      end
    end
  end

  assign o_busy = r_busy;
  assign o_err  = r_err;
  assign {o_wr, o_add, o_wdata} = r_cmd;

endmodule

// File: rtl/bus_arbiter_2m.sv
// Round-robin arbiter sharing one basil byte bus between two single-byte
// masters; registered strobes, fixed read latency, one-cycle ACK per master.
module bus_arbiter_2m
  import bus_arb_pkg::*;
#(
  parameter int ABUSWIDTH  = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 M0_REQ,
  input  logic                 M0_WR,
  input  logic [ABUSWIDTH-1:0] M0_ADD,
  input  logic [7:0]           M0_WDATA,
  output logic                 M0_BUSY,
  output logic                 M0_ACK,
  output logic [7:0]           M0_RDATA,
  output logic                 M0_ERR,
  input  logic                 M1_REQ,
  input  logic                 M1_WR,
  input  logic [ABUSWIDTH-1:0] M1_ADD,
  input  logic [7:0]           M1_WDATA,
  output logic                 M1_BUSY,
  output logic                 M1_ACK,
  output logic [7:0]           M1_RDATA,
  output logic                 M1_ERR,
  output logic                 BUS_WR,
  output logic                 BUS_RD,
  output logic [ABUSWIDTH-1:0] BUS_ADD,
  inout  tri   [7:0]           BUS_DATA,
  output logic [1:0]           DBG_STATE
);

  localparam logic [2:0] LAT = lat_clamp(RD_LATENCY);

  logic [1:0]           r_state;
  logic                 r_grant;
  logic                 r_last;
  logic [2:0]           r_cnt;
  logic                 r_bus_wr;
  logic                 r_bus_rd;
  logic [ABUSWIDTH-1:0] r_bus_add;
  logic [7:0]           r_bus_wdata;
  logic [7:0]           r_rdata0;
  logic [7:0]           r_rdata1;

  logic                 w_pend0, w_pend1;
  logic                 w_wr0, w_wr1;
  logic [ABUSWIDTH-1:0] w_add0, w_add1;
  logic [7:0]           w_wdata0, w_wdata1;
  logic                 w_done0, w_done1;
  logic                 w_pick;
  logic                 w_sel_wr;
  logic [ABUSWIDTH-1:0] w_sel_add;
  logic [7:0]           w_sel_wdata;

  bus_arb_req_slot #(.ABUSWIDTH(ABUSWIDTH)) u_slot0 (
    .clk(BUS_CLK), .rst(BUS_RST),
    .i_req(M0_REQ), .i_wr(M0_WR), .i_add(M0_ADD), .i_wdata(M0_WDATA),
    .i_done(w_done0),
    .o_busy(w_pend0), .o_err(M0_ERR),
    .o_wr(w_wr0), .o_add(w_add0), .o_wdata(w_wdata0)
  );

  bus_arb_req_slot #(.ABUSWIDTH(ABUSWIDTH)) u_slot1 (
    .clk(BUS_CLK), .rst(BUS_RST),
    .i_req(M1_REQ), .i_wr(M1_WR), .i_add(M1_ADD), .i_wdata(M1_WDATA),
    .i_done(w_done1),
    .o_busy(w_pend1), .o_err(M1_ERR),
    .o_wr(w_wr1), .o_add(w_add1), .o_wdata(w_wdata1)
  );

  // With both pending, serve the master that was not served last.
  assign w_pick      = (w_pend0 && w_pend1) ? ~r_last : w_pend1;
  assign w_sel_wr    = w_pick ? w_wr1    : w_wr0;
  assign w_sel_add   = w_pick ? w_add1   : w_add0;
  assign w_sel_wdata = w_pick ? w_wdata1 : w_wdata0;

  assign w_done0 = (r_state == ST_ACK) && !r_grant;
  assign w_done1 = (r_state == ST_ACK) &&  r_grant;

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_state     <= ST_IDLE;
      r_grant     <= 1'b0;
      r_last      <= 1'b1;
      r_cnt       <= 3'd0;
      r_bus_wr    <= 1'b0;
      r_bus_rd    <= 1'b0;
      r_bus_add   <= '0;
      r_bus_wdata <= 8'h00;
      r_rdata0    <= 8'h00;
      r_rdata1    <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pend0 || w_pend1) begin
            r_grant     <= w_pick;
            r_bus_wr    <= w_sel_wr;
            r_bus_rd    <= ~w_sel_wr;
            r_bus_add   <= w_sel_add;
            r_bus_wdata <= w_sel_wdata;
            r_state     <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          r_bus_wr <= 1'b0;
          r_bus_rd <= 1'b0;
          if (r_bus_wr) begin
            r_state <= ST_ACK;
          end else begin
            r_cnt   <= LAT;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Count 1 marks the cycle in which the slave's byte is valid.
          if (r_cnt == 3'd1) begin
            if (r_grant) r_rdata1 <= BUS_DATA;
            else         r_rdata0 <= BUS_DATA;
            r_state <= ST_ACK;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_ACK: begin
          r_last  <= r_grant;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign M0_BUSY   = w_pend0;
  assign M1_BUSY   = w_pend1;
  assign M0_ACK    = w_done0;
  assign M1_ACK    = w_done1;
  assign M0_RDATA  = r_rdata0;
  assign M1_RDATA  = r_rdata1;
  assign BUS_WR    = r_bus_wr;
  assign BUS_RD    = r_bus_rd;
  assign BUS_ADD   = r_bus_add;
  assign BUS_DATA  = r_bus_wr ? r_bus_wdata : 8'hzz;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Directed bench for bus_arbiter_2m: one DUT with read latency 1, one with 3,
// a latency-matched model slave per bus and a pull-up to observe high-Z.
module tb_bus_arbiter_2m;
  import bus_arb_pkg::*;

  localparam int AW = 32;

  logic BUS_CLK = 1'b0;
  logic BUS_RST = 1'b1;
  always #5 BUS_CLK = ~BUS_CLK;

  logic          M0_REQ = 0, M0_WR = 0, M1_REQ = 0, M1_WR = 0;
  logic [AW-1:0] M0_ADD = '0, M1_ADD = '0;
  logic [7:0]    M0_WDATA = '0, M1_WDATA = '0;
  logic          M0_BUSY, M0_ACK, M0_ERR, M1_BUSY, M1_ACK, M1_ERR;
  logic [7:0]    M0_RDATA, M1_RDATA;
  logic          BUS_WR, BUS_RD;
  logic [AW-1:0] BUS_ADD;
  tri   [7:0]    BUS_DATA;
  logic [1:0]    DBG_STATE;

  logic          b_M0_REQ = 0, b_M0_WR = 0, b_M1_REQ = 0, b_M1_WR = 0;
  logic [AW-1:0] b_M0_ADD = '0, b_M1_ADD = '0;
  logic [7:0]    b_M0_WDATA = '0, b_M1_WDATA = '0;
  logic          b_M0_BUSY, b_M0_ACK, b_M0_ERR, b_M1_BUSY, b_M1_ACK, b_M1_ERR;
  logic [7:0]    b_M0_RDATA, b_M1_RDATA;
  logic          b_BUS_WR, b_BUS_RD;
  logic [AW-1:0] b_BUS_ADD;
  tri   [7:0]    b_BUS_DATA;
  logic [1:0]    b_DBG_STATE;

  bus_arbiter_2m #(.ABUSWIDTH(AW), .RD_LATENCY(1)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
    .M0_REQ(M0_REQ), .M0_WR(M0_WR), .M0_ADD(M0_ADD), .M0_WDATA(M0_WDATA),
    .M0_BUSY(M0_BUSY), .M0_ACK(M0_ACK), .M0_RDATA(M0_RDATA), .M0_ERR(M0_ERR),
    .M1_REQ(M1_REQ), .M1_WR(M1_WR), .M1_ADD(M1_ADD), .M1_WDATA(M1_WDATA),
    .M1_BUSY(M1_BUSY), .M1_ACK(M1_ACK), .M1_RDATA(M1_RDATA), .M1_ERR(M1_ERR),
    .BUS_WR(BUS_WR), .BUS_RD(BUS_RD), .BUS_ADD(BUS_ADD), .BUS_DATA(BUS_DATA),
    .DBG_STATE(DBG_STATE)
  );

  bus_arbiter_2m #(.ABUSWIDTH(AW), .RD_LATENCY(3)) dut3 (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
    .M0_REQ(b_M0_REQ), .M0_WR(b_M0_WR), .M0_ADD(b_M0_ADD), .M0_WDATA(b_M0_WDATA),
    .M0_BUSY(b_M0_BUSY), .M0_ACK(b_M0_ACK), .M0_RDATA(b_M0_RDATA), .M0_ERR(b_M0_ERR),
    .M1_REQ(b_M1_REQ), .M1_WR(b_M1_WR), .M1_ADD(b_M1_ADD), .M1_WDATA(b_M1_WDATA),
    .M1_BUSY(b_M1_BUSY), .M1_ACK(b_M1_ACK), .M1_RDATA(b_M1_RDATA), .M1_ERR(b_M1_ERR),
    .BUS_WR(b_BUS_WR), .BUS_RD(b_BUS_RD), .BUS_ADD(b_BUS_ADD), .BUS_DATA(b_BUS_DATA),
    .DBG_STATE(b_DBG_STATE)
  );

  // Model slaves drive the read byte only in the cycle RD_LATENCY after BUS_RD.
  logic [7:0] sl_data = 8'h00;
  logic [3:0] rd_sh = '0, rd_sh3 = '0;
  always @(posedge BUS_CLK) begin
    rd_sh  <= {rd_sh[2:0], BUS_RD};
    rd_sh3 <= {rd_sh3[2:0], b_BUS_RD};
  end
  assign BUS_DATA   = rd_sh[0]  ? sl_data : 8'hzz;
  assign b_BUS_DATA = rd_sh3[2] ? sl_data : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (BUS_DATA[g]);
    pullup (b_BUS_DATA[g]);
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [AW-1:0] exp_q[$];

  task automatic tick();
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++;
    if ({M0_BUSY, M0_ACK, M0_ERR, M1_BUSY, M1_ACK, M1_ERR, BUS_WR, BUS_RD} !== 8'h00)
      $display("FAIL rst_flags: got %b expected 00000000",
               {M0_BUSY, M0_ACK, M0_ERR, M1_BUSY, M1_ACK, M1_ERR, BUS_WR, BUS_RD});
    else n_pass++;
    n_checks++;
    if ({BUS_ADD, M0_RDATA, M1_RDATA} !== '0)
      $display("FAIL rst_data: got add=%h r0=%h r1=%h expected zeros", BUS_ADD, M0_RDATA, M1_RDATA);
    else n_pass++;
    n_checks++;
    if (DBG_STATE !== ST_IDLE) $display("FAIL rst_state: got %0d expected %0d", DBG_STATE, ST_IDLE);
    else n_pass++;
    n_checks++;
    if (BUS_DATA !== 8'hFF) $display("FAIL rst_hiz: got %h expected ff (released)", BUS_DATA);
    else n_pass++;
    BUS_RST = 1'b0;
    tick(); tick();
  endtask

  task automatic test_write();
    logic [3:0] exp_v;
    M0_WR = 1'b1; M0_ADD = 32'h0000_1004; M0_WDATA = 8'hA5; M0_REQ = 1'b1;
    for (int k = 0; k < 7; k++) begin
      exp_v = {k == 2, 1'b0, k == 3, (k >= 1 && k <= 3)};
      n_checks++;
      if ({BUS_WR, BUS_RD, M0_ACK, M0_BUSY} !== exp_v)
        $display("FAIL wr_ctl k=%0d: got %b expected %b", k, {BUS_WR, BUS_RD, M0_ACK, M0_BUSY}, exp_v);
      else n_pass++;
      n_checks++;
      if (BUS_DATA !== ((k == 2) ? 8'hA5 : 8'hFF))
        $display("FAIL wr_data k=%0d: got %h expected %h", k, BUS_DATA, (k == 2) ? 8'hA5 : 8'hFF);
      else n_pass++;
      if (k == 2) begin
        n_checks++;
        if (BUS_ADD !== 32'h0000_1004) $display("FAIL wr_add: got %h expected 00001004", BUS_ADD);
        else n_pass++;
      end
      tick();
      M0_REQ = 1'b0;
    end
  endtask

  task automatic test_read_lat1();
    logic [3:0] exp_v;
    M1_WR = 1'b0; M1_ADD = 32'h20; sl_data = 8'h3C; M1_REQ = 1'b1;
    for (int k = 0; k < 7; k++) begin
      exp_v = {k == 2, 1'b0, k == 4, (k >= 1 && k <= 4)};
      n_checks++;
      if ({BUS_RD, BUS_WR, M1_ACK, M1_BUSY} !== exp_v)
        $display("FAIL rd1_ctl k=%0d: got %b expected %b", k, {BUS_RD, BUS_WR, M1_ACK, M1_BUSY}, exp_v);
      else n_pass++;
      if (k == 2) begin
        n_checks++;
        if (BUS_ADD !== 32'h20) $display("FAIL rd1_add: got %h expected 00000020", BUS_ADD);
        else n_pass++;
      end
      if (k >= 3) begin
        n_checks++;
        if (M1_RDATA !== ((k >= 4) ? 8'h3C : 8'h00))
          $display("FAIL rd1_rdata k=%0d: got %h expected %h", k, M1_RDATA, (k >= 4) ? 8'h3C : 8'h00);
        else n_pass++;
      end
      tick();
      M1_REQ = 1'b0;
    end
  endtask

  task automatic test_read_lat3(input logic [7:0] val, input string tag);
    logic [3:0] exp_v;
    b_M1_WR = 1'b0; b_M1_ADD = 32'h20; sl_data = val; b_M1_REQ = 1'b1;
    for (int k = 0; k < 9; k++) begin
      exp_v = {k == 2, 1'b0, k == 6, (k >= 1 && k <= 6)};
      n_checks++;
      if ({b_BUS_RD, b_BUS_WR, b_M1_ACK, b_M1_BUSY} !== exp_v)
        $display("FAIL %s_ctl k=%0d: got %b expected %b", tag, k,
                 {b_BUS_RD, b_BUS_WR, b_M1_ACK, b_M1_BUSY}, exp_v);
      else n_pass++;
      if (k == 5 || k == 6) begin
        n_checks++;
        if (b_M1_RDATA !== ((k == 6) ? val : 8'h00))
          $display("FAIL %s_rdata k=%0d: got %h expected %h", tag, k, b_M1_RDATA, (k == 6) ? val : 8'h00);
        else n_pass++;
      end
      tick();
      b_M1_REQ = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    int both_hi = 0;
    logic [AW-1:0] a0, a1;
    M0_WR = 1'b1; M1_WR = 1'b1;
    for (int r = 0; r < 5; r++) begin
      a0 = 32'h100 + AW'(r);
      a1 = 32'h200 + AW'(r);
      if (r == 2) begin
        M0_ADD = 32'h150; M0_REQ = 1'b1;
        exp_q.push_back(32'h150);
      end else begin
        M0_ADD = a0; M0_WDATA = 8'(r); M1_ADD = a1; M1_WDATA = 8'(r + 8);
        M0_REQ = 1'b1; M1_REQ = 1'b1;
        if (r < 2) begin exp_q.push_back(a0); exp_q.push_back(a1); end
        else       begin exp_q.push_back(a1); exp_q.push_back(a0); end
      end
      for (int k = 0; k < 10; k++) begin
        if (BUS_WR && BUS_RD) both_hi++;
        if (BUS_WR || BUS_RD) begin
          n_checks++;
          if (exp_q.size() == 0) $display("FAIL rr_order r=%0d: got add=%h expected no strobe", r, BUS_ADD);
          else begin
            if (BUS_ADD !== exp_q[0]) $display("FAIL rr_order r=%0d: got %h expected %h", r, BUS_ADD, exp_q[0]);
            else n_pass++;
            void'(exp_q.pop_front());
          end
        end
        tick();
        M0_REQ = 1'b0; M1_REQ = 1'b0;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rr_missing: got %0d strobes left expected 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (both_hi != 0) $display("FAIL rr_wr_rd_both: got %0d cycles expected 0", both_hi);
    else n_pass++;
  endtask

  task automatic test_err();
    logic [2:0] exp_v;
    M0_WR = 1'b1; M0_ADD = 32'h300; M0_WDATA = 8'h11; M0_REQ = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) begin M0_ADD = 32'h3FF; M0_WDATA = 8'h22; M0_REQ = 1'b1; end
      exp_v = {k == 2, k == 3, k == 2};
      n_checks++;
      if ({M0_ERR, M0_ACK, BUS_WR} !== exp_v)
        $display("FAIL err_ctl k=%0d: got %b expected %b", k, {M0_ERR, M0_ACK, BUS_WR}, exp_v);
      else n_pass++;
      if (k == 2) begin
        n_checks++;
        if ({BUS_ADD, BUS_DATA} !== {32'h300, 8'h11})
          $display("FAIL err_cmd: got %h/%h expected 00000300/11", BUS_ADD, BUS_DATA);
        else n_pass++;
      end
      tick();
      M0_REQ = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic seen_ack = 1'b0;
    b_M1_WR = 1'b0; b_M1_ADD = 32'h40; sl_data = 8'h99; b_M1_REQ = 1'b1;
    tick(); b_M1_REQ = 1'b0;
    tick(); tick(); tick();
    #2 BUS_RST = 1'b1;
    #1;
    n_checks++;
    if ({b_M1_BUSY, b_M1_ACK, b_BUS_RD, b_DBG_STATE} !== 5'b0)
      $display("FAIL rstmid_async: got %b expected 00000", {b_M1_BUSY, b_M1_ACK, b_BUS_RD, b_DBG_STATE});
    else n_pass++;
    n_checks++;
    if (b_M1_RDATA !== 8'h00) $display("FAIL rstmid_rdata: got %h expected 00", b_M1_RDATA);
    else n_pass++;
    tick(); tick();
    BUS_RST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      seen_ack |= b_M1_ACK | b_M1_BUSY;
      tick();
    end
    n_checks++;
    if (seen_ack !== 1'b0) $display("FAIL rstmid_noack: got %b expected 0", seen_ack);
    else n_pass++;
    test_read_lat3(8'h77, "rstmid_fresh");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_v;
    M0_WR = 1'b1;
    for (int k = 0; k < 10; k++) begin
      M0_REQ = 1'b0;
      if (k == 0) begin M0_ADD = 32'h400; M0_WDATA = 8'h40; M0_REQ = 1'b1; end
      if (k == 3) begin M0_ADD = 32'h444; M0_WDATA = 8'h44; M0_REQ = 1'b1; end
      if (k == 4) begin M0_ADD = 32'h500; M0_WDATA = 8'h50; M0_REQ = 1'b1; end
      exp_v = {k == 2 || k == 6, k == 3 || k == 7, k == 4,
               (k >= 1 && k <= 3) || (k >= 5 && k <= 7)};
      n_checks++;
      if ({BUS_WR, M0_ACK, M0_ERR, M0_BUSY} !== exp_v)
        $display("FAIL b2b_ctl k=%0d: got %b expected %b", k, {BUS_WR, M0_ACK, M0_ERR, M0_BUSY}, exp_v);
      else n_pass++;
      if (k == 2 || k == 6) begin
        n_checks++;
        if ({BUS_ADD, BUS_DATA} !== ((k == 2) ? {32'h400, 8'h40} : {32'h500, 8'h50}))
          $display("FAIL b2b_cmd k=%0d: got %h/%h", k, BUS_ADD, BUS_DATA);
        else n_pass++;
      end
      tick();
    end
    M0_REQ = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_lat1();
    test_read_lat3(8'h3C, "rd3");
    test_round_robin();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
